// File: rtl/dual_port_sram_param.sv
// Parametrised true dual-port synchronous SRAM with pipelined reads,
// selectable cross-port read-during-write behaviour and write-write collision counting.
module dual_port_sram_param #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned READ_MODE    = 0,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Port_A_Enable,
  input  logic                  Port_A_Write_Enable,
  input  logic [ADDR_WIDTH-1:0] Port_A_Address_In,
  input  logic [DATA_WIDTH-1:0] Port_A_Data_In,
  output logic [DATA_WIDTH-1:0] Port_A_Data_Out,
  output logic                  Port_A_Data_Valid,
  input  logic                  Port_B_Enable,
  input  logic                  Port_B_Write_Enable,
  input  logic [ADDR_WIDTH-1:0] Port_B_Address_In,
  input  logic [DATA_WIDTH-1:0] Port_B_Data_In,
  output logic [DATA_WIDTH-1:0] Port_B_Data_Out,
  output logic                  Port_B_Data_Valid,
  output logic                  Collision_Out,
  output logic [CNT_WIDTH-1:0]  Collision_Count
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  a_rd_c, a_wr_c, b_rd_c, b_wr_c, b_wr_eff_c;
  logic                  same_addr_c, collision_c;
  logic [DATA_WIDTH-1:0] a_rdata_c, b_rdata_c;

  logic [DATA_WIDTH-1:0] a_s1_data_q, a_s1_data_d, a_s2_data_q, a_s2_data_d;
  logic [DATA_WIDTH-1:0] b_s1_data_q, b_s1_data_d, b_s2_data_q, b_s2_data_d;
  logic                  a_s1_vld_q, a_s1_vld_d, a_s2_vld_q, a_s2_vld_d;
  logic                  b_s1_vld_q, b_s1_vld_d, b_s2_vld_q, b_s2_vld_d;
  logic                  coll_q, coll_d;
  logic [CNT_WIDTH-1:0]  coll_cnt_q, coll_cnt_d;

  // Access decode; read data is resolved at the issue edge, including write-through bypass.
  always_comb begin
    a_rd_c      = Port_A_Enable & ~Port_A_Write_Enable;
    a_wr_c      = Port_A_Enable &  Port_A_Write_Enable;
    b_rd_c      = Port_B_Enable & ~Port_B_Write_Enable;
    b_wr_c      = Port_B_Enable &  Port_B_Write_Enable;
    same_addr_c = (Port_A_Address_In == Port_B_Address_In);
    collision_c = a_wr_c & b_wr_c & same_addr_c;
    b_wr_eff_c  = b_wr_c & ~collision_c;
    a_rdata_c   = mem[Port_A_Address_In];
    b_rdata_c   = mem[Port_B_Address_In];
    if (READ_MODE == 1 && b_wr_c && same_addr_c) a_rdata_c = Port_B_Data_In;
    if (READ_MODE == 1 && a_wr_c && same_addr_c) b_rdata_c = Port_A_Data_In;
  end

  // Array write; port A wins a same-address collision.
  always_ff @(posedge Clk_In) begin
    if (a_wr_c)     mem[Port_A_Address_In] <= Port_A_Data_In;
    if (b_wr_eff_c) mem[Port_B_Address_In] <= Port_B_Data_In;
  end

  // Read pipeline and collision bookkeeping; data stages hold when nothing new arrives.
  always_comb begin
    a_s1_data_d = a_s1_data_q;
    b_s1_data_d = b_s1_data_q;
    a_s2_data_d = a_s2_data_q;
    b_s2_data_d = b_s2_data_q;
    a_s1_vld_d  = a_rd_c;
    b_s1_vld_d  = b_rd_c;
    a_s2_vld_d  = a_s1_vld_q;
    b_s2_vld_d  = b_s1_vld_q;
    coll_d      = collision_c;
    coll_cnt_d  = coll_cnt_q;
    if (a_rd_c)     a_s1_data_d = a_rdata_c;
    if (b_rd_c)     b_s1_data_d = b_rdata_c;
    if (a_s1_vld_q) a_s2_data_d = a_s1_data_q;
    if (b_s1_vld_q) b_s2_data_d = b_s1_data_q;
    if (collision_c && coll_cnt_q != {CNT_WIDTH{1'b1}})
      coll_cnt_d = coll_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      a_s1_data_q <= '0;
      b_s1_data_q <= '0;
      a_s2_data_q <= '0;
      b_s2_data_q <= '0;
      a_s1_vld_q  <= 1'b0;
      b_s1_vld_q  <= 1'b0;
      a_s2_vld_q  <= 1'b0;
      b_s2_vld_q  <= 1'b0;
      coll_q      <= 1'b0;
      coll_cnt_q  <= '0;
    end else begin
      a_s1_data_q <= a_s1_data_d;
      b_s1_data_q <= b_s1_data_d;
      a_s2_data_q <= a_s2_data_d;
      b_s2_data_q <= b_s2_data_d;
      a_s1_vld_q  <= a_s1_vld_d;
      b_s1_vld_q  <= b_s1_vld_d;
      a_s2_vld_q  <= a_s2_vld_d;
      b_s2_vld_q  <= b_s2_vld_d;
      coll_q      <= coll_d;
      coll_cnt_q  <= coll_cnt_d;
    end
  end

  assign Port_A_Data_Out   = (READ_LATENCY == 2) ? a_s2_data_q : a_s1_data_q;
  assign Port_A_Data_Valid = (READ_LATENCY == 2) ? a_s2_vld_q  : a_s1_vld_q;
  assign Port_B_Data_Out   = (READ_LATENCY == 2) ? b_s2_data_q : b_s1_data_q;
  assign Port_B_Data_Valid = (READ_LATENCY == 2) ? b_s2_vld_q  : b_s1_vld_q;
  assign Collision_Out     = coll_q;
  assign Collision_Count   = coll_cnt_q;

endmodule
